// File: rtl/led_view_sched.sv
// rtl/led_view_sched.sv - LED view-select scheduler: debounced manual step, timed auto-rotate, reset-to-low on new instruction.
// The select is the FSM state register itself, so sel and sel_chg are both registered.
module led_view_sched #(
    parameter int DEB_CYCLES   = 500000,
    parameter int DWELL_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       auto_en,
    input  logic       inst_step,
    output logic [1:0] sel,
    output logic       sel_chg
);

    localparam int DCW = $clog2(DEB_CYCLES);
    localparam int TCW = $clog2(DWELL_CYCLES);
    localparam logic [DCW-1:0] DEB_LAST   = DCW'(DEB_CYCLES - 1);
    localparam logic [TCW-1:0] DWELL_LAST = TCW'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        VIEW_LO = 2'b00,
        VIEW_HI = 2'b01,
        VIEW_CU = 2'b10
    } view_t;

    view_t          r_state;
    view_t          w_next;
    logic           r_btn_s1;
    logic           r_btn_s2;
    logic           r_auto_s1;
    logic           r_auto_s2;
    logic           r_db;
    logic           r_db_q;
    logic [DCW-1:0] r_dcnt;
    logic [TCW-1:0] r_tcnt;
    logic           r_sel_chg;
    logic           w_press;
    logic           w_expire;
    logic           w_chg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_s1  <= 1'b0;
            r_btn_s2  <= 1'b0;
            r_auto_s1 <= 1'b0;
            r_auto_s2 <= 1'b0;
        end else begin
            r_btn_s1  <= btn_next;
            r_btn_s2  <= r_btn_s1;
            r_auto_s1 <= auto_en;
            r_auto_s2 <= r_auto_s1;
        end
    end

    // A level is accepted only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db   <= 1'b0;
            r_db_q <= 1'b0;
            r_dcnt <= '0;
        end else begin
            r_db_q <= r_db;
            if (r_btn_s2 == r_db) begin
                r_dcnt <= '0;
            end else if (r_dcnt == DEB_LAST) begin
                r_db   <= r_btn_s2;
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + DCW'(1);
            end
        end
    end

    assign w_press  = r_db & ~r_db_q;
    assign w_expire = (r_tcnt == DWELL_LAST) & r_auto_s2;

    always_comb begin
        w_next = r_state;
        if (inst_step) begin
            w_next = VIEW_LO;
        end else if (w_press || w_expire) begin
            case (r_state)
                VIEW_LO: w_next = VIEW_HI;
                VIEW_HI: w_next = VIEW_CU;
                default: w_next = VIEW_LO;
            endcase
        end
        w_chg = (w_next != r_state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= VIEW_LO;
            r_sel_chg <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_sel_chg <= w_chg;
        end
    end

    // Every view change restarts the dwell, so expiry always coincides with a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
        end else if (!r_auto_s2 || inst_step || w_chg) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + TCW'(1);
        end
    end

    assign sel     = r_state;
    assign sel_chg = r_sel_chg;

endmodule

// File: tb/tb_led_view_sched.sv
// tb/tb_led_view_sched.sv - scoreboard bench for led_view_sched with DEB_CYCLES=4, DWELL_CYCLES=8.
// Stimulus queues (sel, edge number) for each expected change; the monitor pops one per sel_chg.
module tb_led_view_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_next = 1'b0;
    logic       auto_en = 1'b0;
    logic       inst_step = 1'b0;
    logic [1:0] sel;
    logic       sel_chg;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [1:0] sel;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    led_view_sched #(.DEB_CYCLES(4), .DWELL_CYCLES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_next  (btn_next),
        .auto_en   (auto_en),
        .inst_step (inst_step),
        .sel       (sel),
        .sel_chg   (sel_chg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_chg(input logic [1:0] s, input int at);
        exp_t e;
        e.sel = s;
        e.cyc = at;
        sb.push_back(e);
    endtask

    // One clean press from the current negedge; the change lands 7 edges later.
    task automatic press(input logic [1:0] s);
        btn_next = 1'b1;
        expect_chg(s, cyc + 7);
        wait_cyc(15);
        chk("sel_after_press", sel, s);
        btn_next = 1'b0;
        wait_cyc(10);
    endtask

    always @(negedge clk) begin
        if (rst_n && sel_chg) begin
            if (sb.size() == 0) begin
                chk("unexpected_sel_chg", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ev_sel", sel, e.sel);
                chk("ev_edge", cyc, e.cyc);
            end
        end
    end

    initial begin
        int c;
        wait_cyc(3);
        chk("reset_sel", sel, 0);
        chk("reset_sel_chg", sel_chg, 0);
        rst_n = 1'b1;
        wait_cyc(3);

        press(2'b01);
        press(2'b10);
        press(2'b00);

        for (int i = 0; i < 2; i++) begin
            btn_next = 1'b1; wait_cyc(3);
            btn_next = 1'b0; wait_cyc(2);
        end
        wait_cyc(15);
        chk("bounce_sel", sel, 0);

        c = cyc;
        auto_en = 1'b1;
        expect_chg(2'b01, c + 10);
        expect_chg(2'b10, c + 18);
        expect_chg(2'b00, c + 26);
        wait_cyc(30);
        auto_en = 1'b0;
        wait_cyc(30);
        chk("auto_frozen_sel", sel, 0);

        // inst_step, press and expiry all land on the same edge while in VIEW_CU.
        c = cyc;
        auto_en = 1'b1;
        expect_chg(2'b01, c + 10);
        expect_chg(2'b10, c + 18);
        expect_chg(2'b00, c + 26);
        expect_chg(2'b01, c + 34);
        expect_chg(2'b10, c + 42);
        wait_cyc(19);
        btn_next = 1'b1;
        wait_cyc(6);
        inst_step = 1'b1;
        wait_cyc(1);
        inst_step = 1'b0;
        wait_cyc(4);
        btn_next = 1'b0;
        wait_cyc(12);
        auto_en = 1'b0;
        wait_cyc(20);
        chk("prio_end_sel", sel, 2);

        inst_step = 1'b1;
        expect_chg(2'b00, cyc + 1);
        wait_cyc(1);
        inst_step = 1'b0;
        wait_cyc(5);
        chk("step_sel", sel, 0);

        c = cyc;
        auto_en = 1'b1;
        wait_cyc(7);
        inst_step = 1'b1;
        expect_chg(2'b01, c + 16);
        wait_cyc(1);
        inst_step = 1'b0;
        wait_cyc(8);
        auto_en = 1'b0;
        wait_cyc(20);
        chk("step_lo_sel", sel, 1);

        press(2'b10);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_sel", sel, 0);
        chk("async_reset_sel_chg", sel_chg, 0);
        btn_next = 1'b1;
        wait_cyc(3);
        chk("held_reset_sel", sel, 0);
        rst_n = 1'b1;
        expect_chg(2'b01, cyc + 7);
        wait_cyc(6);
        chk("pre_accept_sel", sel, 0);
        wait_cyc(10);
        chk("held_btn_sel", sel, 1);
        btn_next = 1'b0;
        wait_cyc(10);

        chk("sb_empty", sb.size(), 0);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            $display("FAIL missing_event: got none expected sel %0d at edge %0d", e.sel, e.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
